// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared constants and types for the unified-memory arbiter:
//   - ARB_ST_LEN / arb_state_e : FSM state width and encoding
//                                (ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D)
//   - cnt_width()              : bits needed to hold a counter value 0..max
package mem_arbiter_pkg;

  localparam int ARB_ST_LEN = 2;

  typedef enum logic [ARB_ST_LEN-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_e;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch port, data port, memory port and the sticky error
//   flag of the arbiter.
//   modport master : the arbiter itself (drives grants, responses, mem_*)
//   modport slave  : the surroundings (core request ports plus the memory)
//   Fetch port : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   Data port  : d_req, d_we, d_addr, d_wdata, d_wmask -> d_gnt, d_rvalid, d_rdata
//   Memory     : mem_req, mem_we, mem_addr, mem_wdata, mem_wmask ->
//                mem_ready, mem_rvalid, mem_rdata
//   Status     : error
interface mem_arbiter_if #(
  parameter int XLEN = 32
) ();
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_wmask;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_wmask;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            error;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
           mem_ready, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, error
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
           mem_ready, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, error
  );
endinterface

// File: rtl/mem_arb_prio.sv
// mem_arb_prio
//   Grant selection between fetch and data requests. Data wins unless the
//   fetch side has already lost DATA_STREAK_MAX consecutive grants to data
//   while waiting.
//   Ports:
//     clk, reset  clock / asynchronous active-low reset
//     arb_en      arbitration window open (arbiter idle and out of reset)
//     i_req       fetch request
//     d_req       data request
//     ready       memory accepts the selected request this cycle
//     sel_i       fetch port is the current winner
//     sel_d       data port is the current winner
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  input  logic ready,
  output logic sel_i,
  output logic sel_d
);

  localparam int SW = cnt_width(DATA_STREAK_MAX);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  logic [SW-1:0] streak_q, streak_d;
  logic          starve;

  always_comb begin
    // Fetch has waited through a full data streak: it must win this time.
    starve   = i_req && (streak_q == STREAK_MAX);
    sel_d    = arb_en && d_req && !starve;
    sel_i    = arb_en && i_req && !sel_d;
    streak_d = streak_q;
    if (ready && sel_i) begin
      streak_d = '0;
    end else if (ready && sel_d) begin
      // Only data grants taken while fetch is waiting count against it.
      if (!i_req) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch port and the
//   data port. One access is outstanding at a time; the response is routed
//   back to whichever port issued it.
//   Parameters: XLEN, DATA_STREAK_MAX (fetch starvation bound),
//               TIMEOUT_CYCLES (response watchdog limit).
//   Ports:
//     clk    clock, rising edge
//     reset  asynchronous active-low reset
//     bus    mem_arbiter_if.master: fetch/data request ports, memory port,
//            sticky error flag
//   Build option: define MEM_ARB_TIMEOUT_EN to add a response watchdog that
//   abandons an access after TIMEOUT_CYCLES waiting cycles and flags error.
//   Without it the arbiter waits for the memory indefinitely.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  arb_state_e      state_q, state_d;
  logic            error_q, error_d;
  logic            arb_en;
  logic            sel_i, sel_d;
  logic            tmo_hit;
  logic [XLEN-1:0] rsp_data;

  // Gating with reset keeps every combinational output low while reset is
  // asserted, even if requests are already present.
  assign arb_en   = (state_q == ARB_IDLE) && reset;
  assign rsp_data = bus.mem_rdata;
  assign bus.error = error_q;

  mem_arb_prio #(
    .DATA_STREAK_MAX(DATA_STREAK_MAX)
  ) u_prio (
    .clk   (clk),
    .reset (reset),
    .arb_en(arb_en),
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .ready (bus.mem_ready),
    .sel_i (sel_i),
    .sel_d (sel_d)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts waiting cycles; the last permitted waiting cycle is TIMEOUT-1.
  always_comb begin
    tmo_d   = (state_q == ARB_IDLE) ? '0 : tmo_q + 1'b1;
    tmo_hit = (state_q != ARB_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    error_d       = error_q;
    bus.i_gnt     = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = '0;
    bus.d_gnt     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;

    unique case (state_q)
      ARB_IDLE: begin
        // Nothing is outstanding, so a response now is orphaned (e.g. an
        // access cut short by reset): drop it and remember the fault.
        if (bus.mem_rvalid) begin
          error_d = 1'b1;
        end
        if (sel_d) begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = bus.d_we;
          bus.mem_addr  = bus.d_addr;
          bus.mem_wdata = bus.d_wdata;
          bus.mem_wmask = bus.d_wmask;
          bus.d_gnt     = bus.mem_ready;
          if (bus.mem_ready) begin
            state_d = ARB_WAIT_D;
          end
        end else if (sel_i) begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = bus.i_addr;
          bus.i_gnt    = bus.mem_ready;
          if (bus.mem_ready) begin
            state_d = ARB_WAIT_I;
          end
        end
      end
      ARB_WAIT_I: begin
        if (bus.mem_rvalid) begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = rsp_data;
          state_d      = ARB_IDLE;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT_D: begin
        if (bus.mem_rvalid) begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = rsp_data;
          state_d      = ARB_IDLE;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Randomised bench for mem_arbiter. The bench plays both the core (fetch
//   and data requesters) and the memory. A behavioural model (pending flags,
//   a streak integer, a word array standing in for the memory) predicts each
//   cycle's grant and pushes the expected response into a queue; a separate
//   monitor pops that queue whenever the DUT presents i_rvalid/d_rvalid.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_arbiter #(
    .XLEN(XLEN), .DATA_STREAK_MAX(SMAX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } resp_t;

  int checks = 0;
  int errors = 0;
  resp_t exp_q[$];

  // Reference model state
  bit          i_pend, d_pend, busy_m;
  int          streak_m, lat_m;
  logic [31:0] rdata_m;
  logic [31:0] ref_mem [16];

  // Stimulus knobs (percentages / max latency)
  int unsigned i_rate, d_rate, st_rate, rdy_rate, lat_max;

  // Observed grant statistics
  int obs_drun, obs_drun_max, obs_dgnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_wmask = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic model_reset();
    i_pend = 0; d_pend = 0; busy_m = 0; streak_m = 0; lat_m = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One cycle per iteration: new inputs at negedge, check 1 ns later.
  task automatic run(input int n);
    bit want_i, want_d;
    int idx;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!i_pend && $urandom_range(99) < i_rate) begin
        i_pend = 1;
        bus.i_addr = 32'($urandom_range(15)) << 2;
      end
      if (!d_pend && $urandom_range(99) < d_rate) begin
        d_pend = 1;
        bus.d_we    = ($urandom_range(99) < st_rate);
        bus.d_addr  = 32'($urandom_range(15)) << 2;
        bus.d_wdata = $urandom;
        bus.d_wmask = $urandom;
      end
      bus.i_req     = i_pend;
      bus.d_req     = d_pend;
      bus.mem_ready = ($urandom_range(99) < rdy_rate);
      if (busy_m && lat_m == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata_m;
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
      #1;
      chk("error_clear", bus.error, 0);
      if (bus.d_gnt) begin
        obs_dgnt++;
        if (bus.i_req) obs_drun++;
      end
      if (bus.i_gnt) begin
        if (obs_drun > obs_drun_max) obs_drun_max = obs_drun;
        obs_drun = 0;
      end
      if (!busy_m) begin
        want_d = d_pend && !(i_pend && streak_m == SMAX);
        want_i = i_pend && !want_d;
        chk("mem_req", bus.mem_req, want_d || want_i);
        chk("i_gnt", bus.i_gnt, want_i && bus.mem_ready);
        chk("d_gnt", bus.d_gnt, want_d && bus.mem_ready);
        if (want_d) begin
          chk("mem_addr_d", bus.mem_addr, bus.d_addr);
          chk("mem_we_d", bus.mem_we, bus.d_we);
          chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
          chk("mem_wmask", bus.mem_wmask, bus.d_wmask);
        end else if (want_i) begin
          chk("mem_addr_i", bus.mem_addr, bus.i_addr);
          chk("mem_we_i", bus.mem_we, 0);
        end
        if (bus.mem_ready && (want_d || want_i)) begin
          if (want_d) begin
            idx = int'(bus.d_addr[5:2]);
            if (bus.d_we) begin
              rdata_m = $urandom;
              ref_mem[idx] = (ref_mem[idx] & ~bus.d_wmask) | (bus.d_wdata & bus.d_wmask);
            end else begin
              rdata_m = ref_mem[idx];
            end
            streak_m = i_pend ? ((streak_m + 1 > SMAX) ? SMAX : streak_m + 1) : 0;
            d_pend = 0;
          end else begin
            idx = int'(bus.i_addr[5:2]);
            rdata_m = ref_mem[idx];
            streak_m = 0;
            i_pend = 0;
          end
          exp_q.push_back('{is_d: want_d, data: rdata_m});
          busy_m = 1;
          lat_m = int'($urandom_range(lat_max - 1, 0));
        end
      end else begin
        chk("wait_no_req", {bus.mem_req, bus.i_gnt, bus.d_gnt}, 0);
        if (lat_m == 0) busy_m = 0;
        else lat_m--;
      end
    end
  endtask

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!bus.i_rvalid) chk("i_rdata_zero", bus.i_rdata, 0);
      if (!bus.d_rvalid) chk("d_rdata_zero", bus.d_rdata, 0);
      if (bus.i_rvalid || bus.d_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid actual i=%0b d=%0b required none t=%0t",
                   bus.i_rvalid, bus.d_rvalid, $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_d_rvalid", bus.d_rvalid, e.is_d);
          chk("resp_i_rvalid", bus.i_rvalid, !e.is_d);
          chk("resp_data", e.is_d ? bus.d_rdata : bus.i_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'h13;
    model_reset();
    obs_drun = 0; obs_drun_max = 0; obs_dgnt = 0;

    // Reset with requests and a stray response present: everything low.
    drive_idle();
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.mem_ready = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    bus.d_addr = 32'h40; bus.i_addr = 32'h80;
    @(negedge clk); #1;
    chk("rst_ctrl", {bus.i_gnt, bus.d_gnt, bus.mem_req, bus.mem_we,
                     bus.i_rvalid, bus.d_rvalid, bus.error}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    reset = 1'b1;

    // Fetch only, always ready, one-cycle latency: data 0x13 back-to-back.
    i_rate = 100; d_rate = 0; st_rate = 0; rdy_rate = 100; lat_max = 1;
    run(12);

    // Both ports hammering with loads: data streak bounded at SMAX.
    d_rate = 100;
    obs_drun = 0; obs_drun_max = 0;
    run(30);
    chk("streak_max_run", obs_drun_max, SMAX);

    // Directed store held through three not-ready cycles.
    i_rate = 0; d_rate = 0; lat_max = 2;
    run(10);
    d_pend = 1;
    bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hAB; bus.d_wmask = 32'hFF;
    obs_dgnt = 0;
    rdy_rate = 0;
    run(3);
    rdy_rate = 100;
    run(4);
    chk("store_single_gnt", obs_dgnt, 1);

    // Random mix.
    i_rate = 40; d_rate = 40; st_rate = 50; rdy_rate = 60; lat_max = 4;
    run(2000);

    // Drain and confirm every expected response appeared.
    i_rate = 0; d_rate = 0; rdy_rate = 100;
    run(20);
    chk("queue_drained", exp_q.size(), 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Access that never completes: watchdog fires after TMO waiting cycles.
    @(negedge clk);
    drive_idle();
    bus.d_req = 1'b1; bus.d_addr = 32'h8; bus.mem_ready = 1'b1;
    #1;
    chk("tmo_d_gnt", bus.d_gnt, 1);
    for (int w = 0; w < TMO; w++) begin
      @(negedge clk);
      bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'hC; bus.mem_ready = 1'b1;
      #1;
      chk("tmo_wait_no_gnt", bus.i_gnt, 0);
      chk("tmo_wait_err", bus.error, 0);
    end
    @(negedge clk); #1;
    chk("tmo_error", bus.error, 1);
    chk("tmo_i_gnt_next", bus.i_gnt, 1);
    @(negedge clk);
    bus.i_req = 1'b0;
`endif

    // Reset in the middle of a data access, then an orphan response.
    do_reset();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.mem_ready = 1'b1;
    #1;
    chk("rst_mid_d_gnt", bus.d_gnt, 1);
    @(negedge clk);
    bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.mem_req, bus.d_rvalid, bus.error}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_err_clear", bus.error, 0);
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("orphan_no_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    #1;
    chk("orphan_error", bus.error, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("error_sticky", bus.error, 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
